pll_phase_deser: RTL and testbench
==================================

// Module: pll_phase_deser
// PURPOSE
//  Fast-domain deserializer downstream of the PLL-synchronized phase counter.
//  Collects RATIO fast-clock samples into one wide word, indexed by the
//  incoming phase count. Launches the word at a fixed phase so it is stable
//  for the whole slow-clock period, where slow-domain logic captures it.
//  Also qualifies the phase stream (lock FSM) and flags missing samples.
// PARAMETERS
//  RATIO        8   slow/fast clock period ratio; sets slot count, >=2
//  DW           16  sample width, bits
//  LAUNCH_PHASE 0   ctr value on which the assembled word is launched
//  LOCK_WRAPS   4   consecutive clean counter wraps required to declare lock
// PORTS
//  clk        in   1              fast clock
//  rst_n      in   1              synchronous, active-low reset
//  ctr        in   CW             phase count 0..RATIO-1; CW=$clog2(RATIO)
//  di         in   DW             sample
//  di_valid   in   1              di is valid this cycle
//  dout       out  DW*RATIO       assembled word; slot k at [k*DW +: DW]
//  dout_mask  out  RATIO          per-slot valid bits for dout
//  dout_valid out  1              high for RATIO cycles after each launch while locked
//  locked     out  1              phase stream qualified
//  slip       out  1              1-cycle pulse: ctr discontinuity detected
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): dout=0, dout_mask=0, dout_valid=0, locked=0,
//   slip=0, FSM=UNLOCKED, work buffer and mask cleared, wrap count=0.
//  Continuity: prev_ctr is registered every cycle. A step is good when
//   ctr == (prev_ctr==RATIO-1 ? 0 : prev_ctr+1). The first cycle after reset
//   has no prev_ctr and is always good. Any other step is a slip. A ctr value
//   >= RATIO is a slip and is never used as a slot index.
//  FSM:
//   UNLOCKED -> ACQUIRE on first good step.
//   ACQUIRE: on each good wrap (ctr==0 after RATIO-1), wrap count +1.
//    Reaching LOCK_WRAPS -> LOCKED. Any slip -> UNLOCKED, count=0.
//   LOCKED: locked=1. Any slip -> UNLOCKED with locked=0 the next cycle;
//    dout_valid drops the same cycle; dout holds its last value.
//  slip is asserted the cycle after the bad ctr is sampled, in every state.
//  Collection, every cycle with a valid ctr: work[ctr]<=di and mask[ctr]<=1
//   if di_valid, else mask[ctr]<=0; slots are never left stale.
//  Launch, cycle where ctr==LAUNCH_PHASE:
//   - dout/dout_mask load the buffer contents from the preceding RATIO
//     cycles, i.e. slots written before this edge.
//   - The sample written on the launch cycle itself goes to the next word
//     (buffer write and launch read are separate registers; no bypass).
//   - Launch latency: the slot written at phase LAUNCH_PHASE-1 (mod RATIO)
//     appears on dout 1 cycle later.
//   - dout_valid <= locked, held for RATIO cycles until the next launch.
//  Launches while UNLOCKED/ACQUIRE still update dout/dout_mask with
//   dout_valid=0, so the first locked word is fully formed.
//  Slip during collection: clear the whole mask, so the next launched word
//   carries mask=0 in slots not rewritten since the slip.
//  di_valid with an invalid ctr: data dropped, slip pulses.
//  Reset mid-frame: everything returns to reset values; no partial word is
//   emitted.
// STRUCTURE
//  Shared package pll_sync_pkg: CW derivation function, FSM state encoding
//   (UNLOCKED=2'd0, ACQUIRE=2'd1, LOCKED=2'd2), next-phase helper function
//   (wrap at RATIO-1). Shared with pll_sync_ctr consumers.
//  One sub-module, phase_lock_fsm: continuity check, wrap counter, locked,
//   slip. Top level keeps the slot buffer and launch registers.
// TESTING
//  1 Reset, then ctr cycling 0..7 and di=slot index with di_valid=1:
//    locked rises after 4 wraps; then dout = {16'd7,...,16'd0},
//    dout_mask=8'hFF, dout_valid=1 for 8 cycles per launch.
//  2 Locked, then ctr jumps 3->6: slip pulses 1 cycle; locked=0 and
//    dout_valid=0 next cycle; relock after exactly 4 clean wraps.
//  3 di_valid=0 at phases 2 and 5: next dout_mask=8'hDB, other slots correct.
//  4 LAUNCH_PHASE=3: sample at phase 2 appears on dout 1 cycle later; sample
//    at phase 3 lands in the following word.
//  5 rst_n=0 for 1 cycle mid-frame while locked: all outputs 0 next cycle;
//    no stale word launched after release.
//  6 ctr=4'd9 (RATIO=8, CW=3 masked at the bench via RATIO=6, value 7)
//    with di_valid=1: slip pulses; no slot is written.

Source files
------------

// File: rtl/pll_sync_pkg.sv
// Shared definitions for consumers of the PLL-synchronized phase counter:
// counter width derivation, lock FSM encoding and the phase successor rule.
package pll_sync_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_e;

    function automatic int cw_of(input int ratio);
        return $clog2(ratio);
    endfunction

    // Integer form on purpose: an out-of-range previous phase yields a successor no legal ctr can match
    function automatic int next_phase(input int phase, input int ratio);
        return (phase == ratio - 1) ? 0 : phase + 1;
    endfunction

endpackage

// File: rtl/pll_phase_deser_if.sv
// Sample-in / word-out bundle of the phase deserializer.
interface pll_phase_deser_if #(
    parameter int RATIO = 8,
    parameter int DW    = 16
);
    import pll_sync_pkg::*;

    localparam int CW = cw_of(RATIO);

    logic [CW-1:0]       ctr;
    logic [DW-1:0]       di;
    logic                di_valid;
    logic [DW*RATIO-1:0] dout;
    logic [RATIO-1:0]    dout_mask;
    logic                dout_valid;
    logic                locked;
    logic                slip;

    modport master (
        output ctr, di, di_valid,
        input  dout, dout_mask, dout_valid, locked, slip
    );

    modport slave (
        input  ctr, di, di_valid,
        output dout, dout_mask, dout_valid, locked, slip
    );

endinterface

// File: rtl/pll_phase_deser_lock_fsm.sv
// Phase-stream qualification: continuity check, clean-wrap counting, lock and slip flags.
module phase_lock_fsm
    import pll_sync_pkg::*;
#(
    parameter int RATIO      = 8,
    parameter int LOCK_WRAPS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [cw_of(RATIO)-1:0] ctr_i,
    output logic                    good_o,
    output logic                    lock_next_o,
    output logic                    locked_o,
    output logic                    slip_o
);
    localparam int CW = cw_of(RATIO);
    localparam int WW = $clog2(LOCK_WRAPS + 1);

    lock_state_e   state_q, state_d;
    logic [WW-1:0] wraps_q, wraps_d;
    logic [CW-1:0] prev_q;
    logic          first_q;
    logic          slip_q;
    logic          good_s;
    logic          wrap_s;

    // Step classification against the previously sampled phase
    always_comb begin
        good_s = (int'(ctr_i) < RATIO) &&
                 (first_q || (int'(ctr_i) == next_phase(int'(prev_q), RATIO)));
        wrap_s = good_s && !first_q && (int'(prev_q) == RATIO - 1) && (ctr_i == {CW{1'b0}});
    end

    // State, wrap count, previous phase and slip pulse registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_UNLOCKED;
            wraps_q <= {WW{1'b0}};
            prev_q  <= {CW{1'b0}};
            first_q <= 1'b1;
            slip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wraps_q <= wraps_d;
            prev_q  <= ctr_i;
            first_q <= 1'b0;
            slip_q  <= !good_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wraps_d = wraps_q;
        case (state_q)
            ST_UNLOCKED: begin
                wraps_d = {WW{1'b0}};
                if (good_s) state_d = ST_ACQUIRE;
                else        state_d = ST_UNLOCKED;
            end
            ST_ACQUIRE: begin
                if (!good_s) begin
                    state_d = ST_UNLOCKED;
                    wraps_d = {WW{1'b0}};
                end else if (wrap_s) begin
                    if (int'(wraps_q) + 1 >= LOCK_WRAPS) begin
                        state_d = ST_LOCKED;
                        wraps_d = {WW{1'b0}};
                    end else begin
                        wraps_d = wraps_q + WW'(1'b1);
                    end
                end else begin
                    wraps_d = wraps_q;
                end
            end
            ST_LOCKED: begin
                if (!good_s) begin
                    state_d = ST_UNLOCKED;
                    wraps_d = {WW{1'b0}};
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
                wraps_d = {WW{1'b0}};
            end
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        locked_o    = (state_q == ST_LOCKED);
        slip_o      = slip_q;
        good_o      = good_s;
        lock_next_o = (state_d == ST_LOCKED);
    end

endmodule

// File: rtl/pll_phase_deser.sv
// Fast-domain deserializer: gathers RATIO phase-indexed samples and launches the
// word at LAUNCH_PHASE so it is stable across the whole slow-clock period.
module pll_phase_deser
    import pll_sync_pkg::*;
#(
    parameter int RATIO        = 8,
    parameter int DW           = 16,
    parameter int LAUNCH_PHASE = 0,
    parameter int LOCK_WRAPS   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    pll_phase_deser_if.slave   bus
);
    logic                good_s;
    logic                lock_next_s;
    logic                locked_s;
    logic                slip_s;
    logic                ctr_ok_s;
    logic                launch_s;
    logic [RATIO*DW-1:0] work_q, work_d;
    logic [RATIO*DW-1:0] dout_q, dout_d;
    logic [RATIO-1:0]    mask_q, mask_d;
    logic [RATIO-1:0]    dmask_q, dmask_d;
    logic                dvalid_q, dvalid_d;

    phase_lock_fsm #(
        .RATIO      (RATIO),
        .LOCK_WRAPS (LOCK_WRAPS)
    ) u_lock (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctr_i       (bus.ctr),
        .good_o      (good_s),
        .lock_next_o (lock_next_s),
        .locked_o    (locked_s),
        .slip_o      (slip_s)
    );

    // Slot writes and launch; the launch reads the buffer as it stood before this edge
    always_comb begin
        ctr_ok_s = int'(bus.ctr) < RATIO;
        launch_s = ctr_ok_s && (int'(bus.ctr) == LAUNCH_PHASE);
        work_d   = work_q;
        mask_d   = good_s ? mask_q : {RATIO{1'b0}};
        if (ctr_ok_s) begin
            mask_d[bus.ctr] = bus.di_valid;
            if (bus.di_valid) begin
                work_d[int'(bus.ctr)*DW +: DW] = bus.di;
            end else begin
                work_d[int'(bus.ctr)*DW +: DW] = work_q[int'(bus.ctr)*DW +: DW];
            end
        end else begin
            work_d = work_q;
        end
        dout_d   = launch_s ? work_q : dout_q;
        dmask_d  = launch_s ? mask_q : dmask_q;
        dvalid_d = lock_next_s && (launch_s || dvalid_q);
    end

    // Buffer and launch registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work_q   <= {(RATIO*DW){1'b0}};
            mask_q   <= {RATIO{1'b0}};
            dout_q   <= {(RATIO*DW){1'b0}};
            dmask_q  <= {RATIO{1'b0}};
            dvalid_q <= 1'b0;
        end else begin
            work_q   <= work_d;
            mask_q   <= mask_d;
            dout_q   <= dout_d;
            dmask_q  <= dmask_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_mask  = dmask_q;
    assign bus.dout_valid = dvalid_q;
    assign bus.locked     = locked_s;
    assign bus.slip       = slip_s;

endmodule

// File: tb/tb_pll_phase_deser.sv
// Bench for pll_phase_deser: three instances (launch at 0, launch at 3, RATIO=6)
// against a per-instance reference model plus directed scenario checks.
module tb_pll_phase_deser;

    localparam int LW = 4;
    localparam int M_UNLOCKED = 0;
    localparam int M_ACQUIRE  = 1;
    localparam int M_LOCKED   = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pll_phase_deser_if #(.RATIO(8), .DW(16)) if0 ();
    pll_phase_deser_if #(.RATIO(8), .DW(16)) if1 ();
    pll_phase_deser_if #(.RATIO(6), .DW(16)) if2 ();

    pll_phase_deser #(.RATIO(8), .DW(16), .LAUNCH_PHASE(0), .LOCK_WRAPS(LW)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    pll_phase_deser #(.RATIO(8), .DW(16), .LAUNCH_PHASE(3), .LOCK_WRAPS(LW)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));
    pll_phase_deser #(.RATIO(6), .DW(16), .LAUNCH_PHASE(0), .LOCK_WRAPS(LW)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave));

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state, one row per instance
    int          m_prev  [3];
    bit          m_first [3];
    int          m_st    [3];
    int          m_w     [3];
    logic [15:0] m_work  [3][8];
    bit          m_mask  [3][8];
    logic [15:0] m_dout  [3][8];
    bit          m_dmask [3][8];
    bit          m_dv    [3];
    bit          m_lk    [3];
    bit          m_sl    [3];

    int a_ph    = 0;
    int a_sent  = 0;
    int b_cnt   = 0;
    int b_force = -1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int id, input int r, input int l, input int c,
                              input logic [15:0] d, input bit v, input bit rst);
        bit vc, good, wrap, launch;
        if (!rst) begin
            m_first[id] = 1'b1; m_prev[id] = 0; m_st[id] = M_UNLOCKED; m_w[id] = 0;
            for (int k = 0; k < 8; k++) begin
                m_work[id][k] = 16'h0; m_mask[id][k] = 1'b0;
                m_dout[id][k] = 16'h0; m_dmask[id][k] = 1'b0;
            end
            m_dv[id] = 1'b0; m_lk[id] = 1'b0; m_sl[id] = 1'b0;
            return;
        end
        vc     = (c < r);
        good   = vc && (m_first[id] || c == ((m_prev[id] == r - 1) ? 0 : m_prev[id] + 1));
        wrap   = good && !m_first[id] && (m_prev[id] == r - 1) && (c == 0);
        launch = vc && (c == l);
        if (!good) begin
            m_st[id] = M_UNLOCKED; m_w[id] = 0;
        end else if (m_st[id] == M_UNLOCKED) begin
            m_st[id] = M_ACQUIRE;
        end else if (m_st[id] == M_ACQUIRE && wrap) begin
            m_w[id]++;
            if (m_w[id] >= LW) begin m_st[id] = M_LOCKED; m_w[id] = 0; end
        end
        if (launch)
            for (int k = 0; k < r; k++) begin
                m_dout[id][k] = m_work[id][k]; m_dmask[id][k] = m_mask[id][k];
            end
        m_dv[id] = (m_st[id] == M_LOCKED) && (launch || m_dv[id]);
        if (!good)
            for (int k = 0; k < 8; k++) m_mask[id][k] = 1'b0;
        if (vc) begin
            m_mask[id][c] = v;
            if (v) m_work[id][c] = d;
        end
        m_prev[id] = c; m_first[id] = 1'b0;
        m_sl[id] = !good; m_lk[id] = (m_st[id] == M_LOCKED);
    endtask

    function automatic logic [127:0] mdout(input int id, input int r);
        logic [127:0] v = '0;
        for (int k = 0; k < r; k++) v[k*16 +: 16] = m_dout[id][k];
        return v;
    endfunction

    function automatic logic [127:0] mmask(input int id, input int r);
        logic [127:0] v = '0;
        for (int k = 0; k < r; k++) v[k] = m_dmask[id][k];
        return v;
    endfunction

    task automatic check_all();
        check("u0.dout",  if0.dout,       mdout(0, 8));
        check("u0.mask",  if0.dout_mask,  mmask(0, 8));
        check("u0.valid", if0.dout_valid, m_dv[0]);
        check("u0.lock",  if0.locked,     m_lk[0]);
        check("u0.slip",  if0.slip,       m_sl[0]);
        check("u1.dout",  if1.dout,       mdout(1, 8));
        check("u1.mask",  if1.dout_mask,  mmask(1, 8));
        check("u1.valid", if1.dout_valid, m_dv[1]);
        check("u1.lock",  if1.locked,     m_lk[1]);
        check("u1.slip",  if1.slip,       m_sl[1]);
        check("u2.dout",  if2.dout,       mdout(2, 6));
        check("u2.mask",  if2.dout_mask,  mmask(2, 6));
        check("u2.valid", if2.dout_valid, m_dv[2]);
        check("u2.lock",  if2.locked,     m_lk[2]);
        check("u2.slip",  if2.slip,       m_sl[2]);
    endtask

    task automatic tick(input int ca, input logic [15:0] da, input bit va, input bit rst);
        int          cb;
        logic [15:0] db;
        bit          vb;
        @(negedge clk);
        cb = (b_force >= 0) ? b_force : b_cnt;
        if (b_force < 0) b_cnt = (b_cnt + 1) % 6;
        db = 16'($urandom);
        vb = ($urandom_range(0, 3) != 0);
        rst_n = rst;
        if0.ctr = 3'(ca); if0.di = da; if0.di_valid = va;
        if1.ctr = 3'(ca); if1.di = da; if1.di_valid = va;
        if2.ctr = 3'(cb); if2.di = db; if2.di_valid = vb;
        @(posedge clk);
        model_step(0, 8, 0, ca & 7, da, va, rst);
        model_step(1, 8, 3, ca & 7, da, va, rst);
        model_step(2, 6, 0, cb & 7, db, vb, rst);
        #1;
        check_all();
    endtask

    task automatic step_a(input logic [15:0] d, input bit v);
        a_sent = a_ph;
        tick(a_ph, d, v, 1'b1);
        a_ph = (a_ph + 1) % 8;
    endtask

    logic [127:0] exp_word;
    logic [7:0]   vm;
    logic [15:0]  x_val, y_val;
    int           wraps;

    initial begin
        rst_n = 1'b0;
        if0.ctr = 3'd0; if0.di = 16'h0; if0.di_valid = 1'b0;
        if1.ctr = 3'd0; if1.di = 16'h0; if1.di_valid = 1'b0;
        if2.ctr = 3'd0; if2.di = 16'h0; if2.di_valid = 1'b0;
        tick(0, 16'h0, 1'b0, 1'b0);
        tick(0, 16'h0, 1'b0, 1'b0);
        check("rst.dout",  if0.dout,       128'h0);
        check("rst.mask",  if0.dout_mask,  8'h00);
        check("rst.valid", if0.dout_valid, 1'b0);
        check("rst.lock",  if0.locked,     1'b0);
        check("rst.slip",  if0.slip,       1'b0);

        // 1: clean cycling, lock on the 4th wrap, full word on the locking launch
        b_cnt = 0;
        for (int i = 0; i < 33; i++) begin
            step_a(16'(a_ph), 1'b1);
            if (i == 31) check("t1.lock_pre", if0.locked, 1'b0);
        end
        for (int k = 0; k < 8; k++) exp_word[k*16 +: 16] = 16'(k);
        check("t1.lock",  if0.locked,     1'b1);
        check("t1.word",  if0.dout,       exp_word);
        check("t1.mask",  if0.dout_mask,  8'hFF);
        check("t1.valid", if0.dout_valid, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step_a(16'(a_ph), 1'b1);
            check("t1.valid_hold", if0.dout_valid, 1'b1);
        end

        // 2: jump 3->6 while locked, then relock after exactly 4 clean wraps
        while (a_ph != 4) step_a(16'($urandom), 1'b1);
        a_ph = 6;
        step_a(16'($urandom), 1'b1);
        check("t2.slip",  if0.slip,       1'b1);
        check("t2.lock",  if0.locked,     1'b0);
        check("t2.valid", if0.dout_valid, 1'b0);
        step_a(16'($urandom), 1'b1);
        check("t2.slip_end", if0.slip, 1'b0);
        wraps = 0;
        for (int i = 0; i < 25; i++) begin
            step_a(16'($urandom), 1'b1);
            if (a_sent == 0) wraps++;
            check("t2.relock", if0.locked, (wraps >= 4));
        end

        // 3: holes at phases 2 and 5
        while (a_ph != 0) step_a(16'($urandom), 1'b1);
        vm = 8'hDB;
        for (int i = 0; i < 8; i++) step_a(16'h0100 + 16'(a_ph), vm[a_ph]);
        step_a(16'($urandom_range(0, 16'h7FFF)), 1'b1);
        check("t3.mask", if0.dout_mask, 8'hDB);
        for (int k = 0; k < 8; k++)
            if (vm[k]) check("t3.slot", if0.dout[k*16 +: 16], 16'h0100 + 16'(k));

        // 4: launch at phase 3 - phase 2 visible one cycle later, phase 3 goes to the next word
        x_val = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
        y_val = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
        step_a(16'($urandom_range(0, 16'h7FFF)), 1'b1);
        step_a(x_val, 1'b1);
        step_a(y_val, 1'b1);
        check("t4.slot2",     if1.dout[2*16 +: 16], x_val);
        check("t4.slot3_old", if1.dout[3*16 +: 16], 16'h0103);
        for (int i = 0; i < 7; i++) step_a(16'($urandom_range(0, 16'h7FFF)), 1'b1);
        step_a(16'($urandom_range(0, 16'h7FFF)), 1'b1);
        check("t4.slot3_new", if1.dout[3*16 +: 16], y_val);

        // random phase stream with occasional discontinuities
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) a_ph = $urandom_range(0, 7);
            step_a(16'($urandom), ($urandom_range(0, 4) != 0));
        end

        // 5: one-cycle reset mid-frame while locked
        for (int i = 0; i < 48; i++) step_a(16'($urandom), 1'b1);
        check("t5.lock_pre", if0.locked, 1'b1);
        while (a_ph != 4) step_a(16'($urandom), 1'b1);
        tick(4, 16'hFFFF, 1'b1, 1'b0);
        a_ph = 5;
        check("t5.dout",  if0.dout,       128'h0);
        check("t5.mask",  if0.dout_mask,  8'h00);
        check("t5.valid", if0.dout_valid, 1'b0);
        check("t5.lock",  if0.locked,     1'b0);
        check("t5.slip",  if0.slip,       1'b0);
        check("t5.u1dout", if1.dout,      128'h0);
        for (int i = 0; i < 3; i++) begin
            step_a(16'($urandom), 1'b1);
            check("t5.valid_rel", if0.dout_valid, 1'b0);
        end
        step_a(16'($urandom), 1'b1);
        check("t5.mask_rel",  if0.dout_mask,      8'hE0);
        check("t5.low_slots", if0.dout[79:0],     80'h0);
        check("t5.valid_l",   if0.dout_valid,     1'b0);

        // 6: out-of-range phase on the RATIO=6 instance
        b_force = 7;
        step_a(16'($urandom), 1'b1);
        check("t6.slip", if2.slip, 1'b1);
        b_force = -1;
        for (int i = 0; i < 24; i++) step_a(16'($urandom), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
